jk_excitation_driver: RTL
=========================

# jk_excitation_driver

Drives a bank of WIDTH JK flip-flops toward a requested next state, one target word per transaction. It applies the JK excitation table to the current flip-flop outputs and target to produce J/K, holds J/K for exactly one clock, then reads the bank back and flags any bit that failed to land. It is the stimulus-and-check counterpart of the D-flip-flop-plus-gates JK flip-flop. It sits between a sequence source (valid/ready) and the flip-flop bank, whose Q outputs feed back on q_fb.

## Interface
- WIDTH, 4: number of JK flip-flops driven.
- USE_TOGGLE, 0: 0 resolves transitions with set/reset codes (01/10); 1 resolves them with toggle (11).

- clk  input  1  rising-edge clock, shared with the flip-flop bank.
- reset_async  input  1  asynchronous, active-high reset.
- in_valid  input  1  target word offered.
- in_ready  output  1  block accepts a target this cycle.
- in_target  input  WIDTH  requested next state of the bank.
- q_fb  input  WIDTH  Q outputs of the bank.
- j  output  WIDTH  J drive to the bank, registered.
- k  output  WIDTH  K drive to the bank, registered.
- done  output  1  one-cycle pulse when a transaction completes.
- mismatch  output  1  one-cycle pulse, coincident with done, when q_fb != target.
- hold_err  output  1  one-cycle pulse when q_fb changes while idle.
- err_count  output  8  saturating count of mismatch plus hold_err events.

## Operation
- Reset, asynchronous and immediate: state IDLE; j=0, k=0, done=0, mismatch=0, hold_err=0, err_count=0, in_ready=0, q_ref=0, target register=0.
  - in_ready rises on the first clk edge after reset_async falls.
  - The bank must also reset to 0.
- FSM states: IDLE, DRIVE, CHECK.
- **IDLE:**
  - in_ready=1, j=k=0.
  - Accept when in_valid && in_ready at an edge: latch in_target, go to DRIVE, clear in_ready.
  - At the same edge, register j/k from q_fb sampled at that edge and in_target, per bit:
    - q=0, t=0: J=0, K=0.
    - q=1, t=1: J=0, K=0.
    - q=0, t=1: J=1, K=0 (USE_TOGGLE=0) or J=1, K=1 (USE_TOGGLE=1).
    - q=1, t=0: J=0, K=1 (USE_TOGGLE=0) or J=1, K=1 (USE_TOGGLE=1).
- **DRIVE** (one cycle): the bank samples j/k at the next edge. At that edge j,k←0 and the state goes to CHECK.
- **CHECK** (one cycle): at the next edge the block samples q_fb, then:
  - done←1 for one cycle.
  - mismatch←(q_fb != target) for one cycle.
  - q_ref←q_fb (the actual value, so a failed bit is not re-flagged while idle).
  - State→IDLE and in_ready←1.
- **Hold check:**
  - At every edge while in IDLE, including the accept edge: if q_fb != q_ref, pulse hold_err for one cycle and set q_ref←q_fb.
  - With j=k=0 a correct bank never changes.
- **err_count:** +1 per mismatch or hold_err pulse, saturating at 255. The two events cannot share an edge, because hold_err is evaluated only in IDLE.
- in_valid is ignored outside IDLE, and in_target is not required to stay stable after acceptance.

## Timing
- Edge E0: accept.
  - j/k are valid from after E0 until E1 (exactly one cycle).
- Edge E1: the bank updates Q; j/k return to 0.
- Edge E2: compare; done/mismatch are high during the cycle after E2; in_ready is 1 after E2.
- Throughput: one target per 3 cycles. A new accept is possible at E3.
- Reset mid-transaction, any state: j/k drop to 0 asynchronously, the target is discarded, and no done is issued.
- Reset release: first accept possible at the second edge after release, since in_ready is 0 until the first edge.
- in_ready, done, mismatch and hold_err are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert reset_async mid-cycle.
  - All outputs are 0 immediately.
  - After release, in_ready=1 following one edge; err_count=0.
- **Set/reset codes** (WIDTH=4, USE_TOGGLE=0, behavioural JK bank):
  - q=0000, target 1010: j=1010, k=0000 for one cycle; q becomes 1010; done pulses; mismatch=0.
  - Next target 0110: j=0100, k=1000; q becomes 0110; mismatch=0.
- **Toggle mode** (USE_TOGGLE=1):
  - q=1010, target 0110: j=1100, k=1100.
  - Target 0110 again: j=0000, k=0000; done pulses; mismatch=0.
- **Faulty bank** (bit0 stuck at 0), target 0001:
  - mismatch pulses with done; err_count=1.
  - No hold_err on the following idle cycles.
- **Hold violation and saturation:**
  - Flip a bank bit while IDLE: hold_err pulses once; err_count increments.
  - Inject 300 faults: err_count stays at 255.
- **Reset mid-transaction:** assert reset_async during DRIVE.
  - j/k go to 0 within the same cycle; no done.
  - After release, a new target completes normally in 3 cycles.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: turns a target word into a one-cycle J/K drive for a JK
// flip-flop bank, then reads the bank back and flags bits that failed or drifted.
module jk_excitation_driver #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             mismatch,
  output logic             hold_err,
  output logic [7:0]       err_count
);

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] q_ref_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] diff;
  logic             in_ready_q;
  logic             done_q;
  logic             mismatch_q;
  logic             hold_err_q;
  logic [CntW-1:0]  err_count_q;
  logic [CntW-1:0]  err_count_d;

  // Excitation: only bits that must change get a drive; toggle mode uses J=K=1.
  always_comb begin
    diff = q_fb ^ in_target;
    if (USE_TOGGLE) begin
      j_d = diff;
      k_d = diff;
    end else begin
      j_d = diff & in_target;
      k_d = diff & q_fb;
    end
  end

  assign err_count_d = (err_count_q == {CntW{1'b1}}) ? err_count_q
                                                     : err_count_q + CntW'(1);

  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      state_q     <= IDLE;
      target_q    <= '0;
      q_ref_q     <= '0;
      j_q         <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      hold_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      hold_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The bank is undriven here, so any movement is a hold violation.
          if (q_fb != q_ref_q) begin
            hold_err_q  <= 1'b1;
            q_ref_q     <= q_fb;
            err_count_q <= err_count_d;
          end
          if (in_valid && in_ready_q) begin
            target_q   <= in_target;
            j_q        <= j_d;
            k_q        <= k_d;
            in_ready_q <= 1'b0;
            state_q    <= DRIVE;
          end else begin
            in_ready_q <= 1'b1;
            j_q        <= '0;
            k_q        <= '0;
          end
        end
        DRIVE: begin
          j_q     <= '0;
          k_q     <= '0;
          state_q <= CHECK;
        end
        CHECK: begin
          done_q     <= 1'b1;
          mismatch_q <= (q_fb != target_q);
          if (q_fb != target_q) begin
            err_count_q <= err_count_d;
          end
          // Track the real bank value so a failed bit is not re-flagged as drift.
          q_ref_q    <= q_fb;
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          j_q        <= '0;
          k_q        <= '0;
          in_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign hold_err  = hold_err_q;
  assign err_count = err_count_q;

endmodule
